// File: rtl/immgen_stage.sv
// immgen_stage: registered immediate-generation stage between decode and ID/EX.
// Extends the immediate of an incoming instruction (bits [31:7]) by format code,
// flags illegal codes, and buffers results in a 2-entry skid (M drives outputs,
// S catches one extra result) so in_ready_o never depends on out_ready_i.
// Optional build macro: IMMGEN_ERRCNT_EN adds err_cnt_o, a saturating 16-bit
// count of accepted inputs with an illegal format code.
module immgen_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [24:0]       in_instr_i,
  input  logic [3:0]        in_immsrc_i,
  input  logic [TAG_W-1:0]  in_tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   out_imm_o,
  output logic [TAG_W-1:0]  out_tag_o,
  output logic              out_err_o
`ifdef IMMGEN_ERRCNT_EN
  ,
  output logic [15:0]       err_cnt_o
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Immediate extension; ins is indexed with the instruction's own bit numbers.
  // The unsigned B form is the 12-bit branch offset, without the sign bit i31.
  function automatic logic [XLEN-1:0] ext_imm(input logic [31:7] ins, input logic [3:0] src);
    logic [XLEN-1:0] v;
    v = '0;
    case (src)
      4'b0000: v = XLEN'($signed(ins[31:20]));
      4'b0001: v = XLEN'($signed({ins[31:25], ins[11:7]}));
      4'b0010: v = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      4'b0011: v = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      4'b0100: v = XLEN'(ins[31:20]);
      4'b0101: v = (XLEN == 32'sd32) ? XLEN'(ins[24:20]) : XLEN'(ins[25:20]);
      4'b0110: v = XLEN'({ins[7], ins[30:25], ins[11:8], 1'b0});
      4'b0111: v = XLEN'($signed({ins[31:12], 12'd0}));
      4'b1000: v = XLEN'(ins[19:15]);
      default: v = '0;
    endcase
    return v;
  endfunction

  state_t            state_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [XLEN-1:0]   m_imm_r;
  logic [TAG_W-1:0]  m_tag_r;
  logic              m_err_r;
  logic [XLEN-1:0]   s_imm_r;
  logic [TAG_W-1:0]  s_tag_r;
  logic              s_err_r;

  logic [XLEN-1:0]   new_imm_s;
  logic              new_err_s;
  logic              in_fire_s;
  logic              out_fire_s;

  // Extend the incoming immediate and qualify both handshakes.
  always_comb begin
    new_imm_s  = ext_imm(in_instr_i, in_immsrc_i);
    new_err_s  = (in_immsrc_i > 4'b1000);
    in_fire_s  = in_valid_i & in_ready_r & ~flush_i;
    out_fire_s = out_valid_r & out_ready_i;
  end

  // Skid FSM: moves results through M and S in strict FIFO order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      m_imm_r     <= '0;
      m_tag_r     <= '0;
      m_err_r     <= 1'b0;
      s_imm_r     <= '0;
      s_tag_r     <= '0;
      s_err_r     <= 1'b0;
    end else if (flush_i) begin
      // Data registers keep their contents; only occupancy is dropped.
      state_r     <= EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            m_imm_r     <= new_imm_s;
            m_tag_r     <= in_tag_i;
            m_err_r     <= new_err_s;
            state_r     <= ONE;
            out_valid_r <= 1'b1;
          end
        end
        ONE: begin
          if (in_fire_s && out_fire_s) begin
            m_imm_r <= new_imm_s;
            m_tag_r <= in_tag_i;
            m_err_r <= new_err_s;
          end else if (in_fire_s) begin
            s_imm_r    <= new_imm_s;
            s_tag_r    <= in_tag_i;
            s_err_r    <= new_err_s;
            state_r    <= FULL;
            in_ready_r <= 1'b0;
          end else if (out_fire_s) begin
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
          end
        end
        FULL: begin
          if (out_fire_s) begin
            m_imm_r    <= s_imm_r;
            m_tag_r    <= s_tag_r;
            m_err_r    <= s_err_r;
            state_r    <= ONE;
            in_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= EMPTY;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_r;
  assign out_valid_o = out_valid_r;
  assign out_imm_o   = m_imm_r;
  assign out_tag_o   = m_tag_r;
  assign out_err_o   = m_err_r;

`ifdef IMMGEN_ERRCNT_EN
  logic [15:0] err_cnt_r;

  // Saturating count of accepted inputs carrying an illegal format code.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_r <= 16'd0;
    end else if (in_fire_s && new_err_s && (err_cnt_r != 16'hFFFF)) begin
      err_cnt_r <= err_cnt_r + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_r;
`endif

endmodule

// File: tb/tb_immgen_stage.sv
// tb_immgen_stage: drives an XLEN=32 and an XLEN=64 instance with shared
// stimulus and compares both against a queue-based reference model.
module tb_immgen_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [24:0] instr;
  logic [3:0]  src;
  logic [4:0]  tag;

  logic        rdy32, rdy64, v32, v64, err32, err64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [4:0]  tag32, tag64;
`ifdef IMMGEN_ERRCNT_EN
  logic [15:0] ec32, ec64;
`endif

  immgen_stage #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(rdy32),
    .in_instr_i(instr), .in_immsrc_i(src), .in_tag_i(tag),
    .out_valid_o(v32), .out_ready_i(out_ready),
    .out_imm_o(imm32), .out_tag_o(tag32), .out_err_o(err32)
`ifdef IMMGEN_ERRCNT_EN
    , .err_cnt_o(ec32)
`endif
  );

  immgen_stage #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(rdy64),
    .in_instr_i(instr), .in_immsrc_i(src), .in_tag_i(tag),
    .out_valid_o(v64), .out_ready_i(out_ready),
    .out_imm_o(imm64), .out_tag_o(tag64), .out_err_o(err64)
`ifdef IMMGEN_ERRCNT_EN
    , .err_cnt_o(ec64)
`endif
  );

  typedef struct packed {
    logic [24:0] instr;
    logic [3:0]  src;
    logic [4:0]  tag;
  } ent_t;

  ent_t       q[$];
  logic [4:0] fired[$];
  int         ecnt;
  int         tests;
  int         fails;

  // Compare one observed value with its expectation.
  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference immediate built from field weights with plain arithmetic.
  function automatic logic [63:0] ref_imm(input logic [24:0] f, input logic [3:0] s, input int xlen);
    logic [31:0] i;
    logic [63:0] v;
    i = {f, 7'd0};
    case (s)
      4'd0: v = i[31:20] - (i[31] ? 64'd4096 : 64'd0);
      4'd1: v = {i[31:25], i[11:7]} - (i[31] ? 64'd4096 : 64'd0);
      4'd2: v = i[7] * 64'd2048 + i[30:25] * 64'd32 + i[11:8] * 64'd2 - (i[31] ? 64'd4096 : 64'd0);
      4'd3: v = i[19:12] * 64'd4096 + i[20] * 64'd2048 + i[30:21] * 64'd2 - (i[31] ? 64'd1048576 : 64'd0);
      4'd4: v = 64'(i[31:20]);
      4'd5: v = (xlen == 32) ? 64'(i[24:20]) : 64'(i[25:20]);
      4'd6: v = i[7] * 64'd2048 + i[30:25] * 64'd32 + i[11:8] * 64'd2;
      4'd7: v = i[31:12] * 64'd4096 - (i[31] ? 64'h1_0000_0000 : 64'd0);
      4'd8: v = 64'(i[19:15]);
      default: v = 64'd0;
    endcase
    if (xlen == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  task automatic check_outputs;
    check_val("rdy32", rdy32, q.size() < 2);
    check_val("rdy64", rdy64, q.size() < 2);
    check_val("vld32", v32, q.size() > 0);
    check_val("vld64", v64, q.size() > 0);
    if (q.size() > 0) begin
      check_val("imm32", imm32, ref_imm(q[0].instr, q[0].src, 32));
      check_val("imm64", imm64, ref_imm(q[0].instr, q[0].src, 64));
      check_val("tag32", tag32, q[0].tag);
      check_val("tag64", tag64, q[0].tag);
      check_val("err32", err32, q[0].src >= 4'd9);
      check_val("err64", err64, q[0].src >= 4'd9);
    end
`ifdef IMMGEN_ERRCNT_EN
    check_val("ecnt32", ec32, ecnt);
    check_val("ecnt64", ec64, ecnt);
`endif
  endtask

  // One clock: predict handshakes, advance the model, then check the DUTs.
  task automatic step;
    bit   inf, outf;
    ent_t e;
    inf  = !rst && !flush && in_valid && (q.size() < 2);
    outf = !rst && (q.size() > 0) && out_ready;
    e    = '{instr, src, tag};
    if (!rst && v32 && out_ready) fired.push_back(tag32);
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      ecnt = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back(e);
    end
    if (inf && src >= 4'd9 && ecnt < 65535) ecnt++;
    check_outputs();
  endtask

  task automatic push(input logic [31:0] w, input logic [3:0] s, input logic [4:0] t);
    in_valid = 1'b1;
    instr    = w[31:7];
    src      = s;
    tag      = t;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0; ecnt = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = 25'd0; src = 4'd0; tag = 5'd0;
    step();
    step();
    rst = 1'b0;
    check_val("rst_imm32", imm32, 64'd0);
    check_val("rst_imm64", imm64, 64'd0);
    check_val("rst_tag", tag32, 64'd0);
    check_val("rst_err", err32, 64'd0);
    check_val("rst_rdy", rdy32, 64'd1);

    // Directed immediates
    out_ready = 1'b1;
    push(32'hFFF00093, 4'b0000, 5'd1);
    check_val("I_s32", imm32, 64'hFFFF_FFFF);
    check_val("I_s_err", err32, 64'd0);
    push(32'hFE000EE3, 4'b0010, 5'd2);
    check_val("B_s32", imm32, 64'hFFFF_FFFC);
    check_val("B_s64", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    push(32'hFE000EE3, 4'b0110, 5'd3);
    check_val("B_z32", imm32, 64'h0000_0FFC);
    push(32'h800000B7, 4'b0111, 5'd4);
    check_val("U64", imm64, 64'hFFFF_FFFF_8000_0000);
    check_val("U32", imm32, 64'h8000_0000);
    push(32'h43F0D093, 4'b0101, 5'd5);
    check_val("shamt64", imm64, 64'd63);
    check_val("shamt32", imm32, 64'd31);
    step();

    // Illegal codes and counter reset
    for (int k = 0; k < 3; k++) begin
      push(32'h12345678, 4'b1010, 5'(k + 6));
      check_val("ill_imm", imm32, 64'd0);
      check_val("ill_err", err32, 64'd1);
    end
`ifdef IMMGEN_ERRCNT_EN
    check_val("errcnt3", ec32, 64'd3);
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("rst2_vld", v32, 64'd0);
`ifdef IMMGEN_ERRCNT_EN
    check_val("errcnt_rst", ec32, 64'd0);
`endif

    // Backpressure: fill, hold a third push, then drain in order
    out_ready = 1'b0;
    fired.delete();
    push(32'h00100093, 4'b0000, 5'd1);
    push(32'h00200093, 4'b0000, 5'd2);
    check_val("bp_full_rdy", rdy32, 64'd0);
    in_valid = 1'b1; instr = 25'h1ABCD; src = 4'b0001; tag = 5'd3;
    step();
    check_val("bp_held_rdy", rdy32, 64'd0);
    check_val("bp_head", tag32, 64'd1);
    out_ready = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    step();
    step();
    check_val("bp_count", fired.size(), 64'd3);
    for (int k = 0; k < 3 && k < fired.size(); k++) check_val("bp_order", fired[k], 64'(k + 1));

    // Streaming at full rate
    fired.delete();
    for (int k = 0; k < 8; k++) push(32'($urandom), 4'($urandom_range(0, 8)), 5'(10 + k));
    step();
    check_val("st_count", fired.size(), 64'd8);
    for (int k = 0; k < 8 && k < fired.size(); k++) check_val("st_order", fired[k], 64'(10 + k));

    // Flush while full with a pending input
    out_ready = 1'b0;
    push(32'hFFF00093, 4'b0000, 5'd20);
    push(32'hFFF00093, 4'b0000, 5'd21);
    in_valid = 1'b1; tag = 5'd22; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_val("fl_vld", v32, 64'd0);
    check_val("fl_rdy", rdy32, 64'd1);
    out_ready = 1'b1;
    fired.delete();
    for (int k = 0; k < 4; k++) step();
    check_val("fl_none", fired.size(), 64'd0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      instr     = 25'($urandom);
      src       = 4'($urandom_range(0, 15));
      tag       = 5'($urandom);
      step();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
